// File: rtl/riscv_commit_monitor.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_commit_monitor
//  Purpose  : Commit-checking harness placed beside a RISC-V core. It sequences
//             the core reset, compares every register-file writeback against a
//             FIFO of expected (rd, data) pairs, and detects halt (stable PC)
//             and timeout. The result is reported as done/pass/timeout.
//  Ports    : clk, reset (sync, active-low)      - clock / monitor reset
//             core_rst                           - active-high reset to core
//             pc, wb_en, wb_rd, wb_data          - core observation
//             exp_valid/exp_ready/exp_rd/exp_data - expected-commit push port
//             commit_count, mismatch_count,
//             cycle_count                        - saturating 32-bit counters
//             done, pass, timeout                - run status
//             fail_pc, fail_rd, fail_data        - first-mismatch capture
//  Config   : RVMON_FIRST_FAIL_CAPTURE_EN - build the first-mismatch capture
//             registers; otherwise fail_* are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module riscv_commit_monitor #(
   parameter int XLEN        = 64,
   parameter int DEPTH       = 16,
   parameter int RST_HOLD    = 4,
   parameter int HALT_STABLE = 8,
   parameter int TIMEOUT     = 4096
) (
   input  logic            clk,
   input  logic            reset,
   output logic            core_rst,
   input  logic [XLEN-1:0] pc,
   input  logic            wb_en,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
   input  logic            exp_valid,
   output logic            exp_ready,
   input  logic [4:0]      exp_rd,
   input  logic [XLEN-1:0] exp_data,
   output logic [31:0]     commit_count,
   output logic [31:0]     mismatch_count,
   output logic [31:0]     cycle_count,
   output logic            done,
   output logic            pass,
   output logic            timeout,
   output logic [XLEN-1:0] fail_pc,
   output logic [4:0]      fail_rd,
   output logic [XLEN-1:0] fail_data
);

   localparam int c_AW     = $clog2(DEPTH);
   localparam int c_HOLD_W = $clog2(RST_HOLD + 1);
   localparam int c_HS_W   = $clog2(HALT_STABLE + 1);
   localparam logic [c_HOLD_W-1:0] c_RST_HOLD    = c_HOLD_W'(RST_HOLD);
   localparam logic [c_HS_W-1:0]   c_HALT_STABLE = c_HS_W'(HALT_STABLE);
   localparam logic [31:0]         c_TIMEOUT     = 32'(TIMEOUT);

   typedef enum logic [1:0] {
      ST_HOLD = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t r_state, w_state_next;

   logic [c_HOLD_W-1:0] r_hold_cnt;
   logic [c_HS_W-1:0]   r_stable, w_stable_next;
   logic [XLEN-1:0]     r_prev_pc;
   logic [31:0]         r_commit_cnt, r_mismatch_cnt, r_cycle_cnt, w_cycle_inc;
   logic                r_timeout;

   // Expected-commit FIFO; pointers carry one extra wrap bit for full/empty.
   logic [XLEN+4:0] r_mem [DEPTH];
   logic [c_AW:0]   r_wptr, r_rptr;
   logic            w_full, w_empty, w_push, w_pop;
   logic [XLEN+4:0] w_head;

   logic w_commit, w_mismatch, w_halt_hit, w_to_hit;

   function automatic logic [31:0] f_sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   assign w_empty = (r_wptr == r_rptr);
   assign w_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                    (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
   assign w_head  = r_mem[r_rptr[c_AW-1:0]];

   // Gated by reset so the port reads 0 during the reset cycle itself.
   assign exp_ready = reset && !w_full && (r_state != ST_DONE);
   assign w_push    = exp_valid && exp_ready;

   // Writes to x0 are not architectural commits and are ignored entirely.
   assign w_commit   = (r_state == ST_RUN) && wb_en && (wb_rd != 5'd0);
   assign w_pop      = w_commit && !w_empty;
   assign w_mismatch = w_commit && (w_empty ||
                                    (w_head[XLEN+4:XLEN] != wb_rd) ||
                                    (w_head[XLEN-1:0] != wb_data));

   always_comb begin
      w_cycle_inc   = f_sat_inc(r_cycle_cnt);
      w_stable_next = '0;
      if (pc == r_prev_pc) begin
         w_stable_next = (r_stable == c_HALT_STABLE) ? r_stable : r_stable + 1'b1;
      end
      w_halt_hit = (r_state == ST_RUN) && (w_stable_next == c_HALT_STABLE);
      w_to_hit   = (r_state == ST_RUN) && (w_cycle_inc == c_TIMEOUT);
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_HOLD: if (r_hold_cnt == c_RST_HOLD) w_state_next = ST_RUN;
         ST_RUN:  if (w_halt_hit || w_to_hit)    w_state_next = ST_DONE;
         default: w_state_next = ST_DONE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= ST_HOLD;
         r_hold_cnt     <= '0;
         r_stable       <= '0;
         r_prev_pc      <= '0;
         r_commit_cnt   <= '0;
         r_mismatch_cnt <= '0;
         r_cycle_cnt    <= '0;
         r_timeout      <= 1'b0;
         r_wptr         <= '0;
         r_rptr         <= '0;
      end else begin
         r_state   <= w_state_next;
         r_prev_pc <= pc;
         if (r_state == ST_HOLD && r_hold_cnt != c_RST_HOLD) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
         end
         if (r_state == ST_RUN) begin
            r_stable    <= w_stable_next;
            r_cycle_cnt <= w_cycle_inc;
         end else begin
            r_stable <= '0;
         end
         // Timeout takes priority over a coincident halt.
         if (w_to_hit) r_timeout <= 1'b1;
         if (w_commit)   r_commit_cnt   <= f_sat_inc(r_commit_cnt);
         if (w_mismatch) r_mismatch_cnt <= f_sat_inc(r_mismatch_cnt);
         if (w_push) r_wptr <= r_wptr + 1'b1;
         if (w_pop)  r_rptr <= r_rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr[c_AW-1:0]] <= {exp_rd, exp_data};
   end

`ifdef RVMON_FIRST_FAIL_CAPTURE_EN
   logic            r_fail_seen;
   logic [XLEN-1:0] r_fail_pc, r_fail_data;
   logic [4:0]      r_fail_rd;

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_fail_seen <= 1'b0;
         r_fail_pc   <= '0;
         r_fail_rd   <= '0;
         r_fail_data <= '0;
      end else if (w_mismatch && !r_fail_seen) begin
         r_fail_seen <= 1'b1;
         r_fail_pc   <= pc;
         r_fail_rd   <= wb_rd;
         r_fail_data <= wb_data;
      end
   end

   assign fail_pc   = r_fail_pc;
   assign fail_rd   = r_fail_rd;
   assign fail_data = r_fail_data;
`else
   assign fail_pc   = '0;
   assign fail_rd   = '0;
   assign fail_data = '0;
`endif

   assign core_rst       = !reset || (r_state == ST_HOLD);
   assign commit_count   = r_commit_cnt;
   assign mismatch_count = r_mismatch_cnt;
   assign cycle_count    = r_cycle_cnt;
   assign done           = (r_state == ST_DONE);
   assign timeout        = r_timeout;
   // Leftover expected entries count as a failure.
   assign pass = done && !r_timeout && (r_mismatch_cnt == 32'd0) && w_empty;

endmodule
`default_nettype wire
